led_pattern_gen: RTL and testbench

Parametrised LED pattern engine for the board's red LED bank, driven from the 12 MHz CLK_IN. A free-running prescaler produces a step tick, and a selectable mode advances an LED pattern on each tick. The four modes are binary count, bounce scan, PWM breathing and ring rotate. It sits directly under the top level between CLK_IN and the LED pins, replacing the fixed binary counter.

---
 rtl/led_pattern_gen.sv | 170 +++++++++++++++++
 tb/tb_led_pattern_gen.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// LED pattern engine: prescaled step tick drives binary count, bounce scan,
// PWM breathing or ring rotation on the LED bank, selected by a synchronised MODE.
module led_pattern_gen #(
    parameter int unsigned NUM_LEDS  = 4,
    parameter int unsigned DIV_WIDTH = 22,
    parameter int unsigned PWM_WIDTH = 8
) (
    input  logic                CLK_IN,
    input  logic                RST_N,
    input  logic [1:0]          MODE,
    output logic [NUM_LEDS-1:0] LED,
    output logic                TICK,
    output logic [1:0]          MODE_ACT
);

    typedef enum logic [1:0] {
        ModeBinary  = 2'd0,
        ModeScan    = 2'd1,
        ModeBreathe = 2'd2,
        ModeRotate  = 2'd3
    } mode_e;

    typedef enum logic {
        DirUp   = 1'b0,
        DirDown = 1'b1
    } dir_e;

    localparam int unsigned POS_WIDTH = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam logic [POS_WIDTH-1:0] POS_MAX = POS_WIDTH'(NUM_LEDS - 1);
    localparam logic [PWM_WIDTH-1:0] DUTY_MAX = '1;

    logic [DIV_WIDTH-1:0] prescaler_q, prescaler_d;
    logic [1:0]           mode_meta_q;
    mode_e                mode_req_q;
    mode_e                mode_act_q, mode_act_d;
    logic [NUM_LEDS-1:0]  step_q, step_d;
    logic [POS_WIDTH-1:0] pos_q, pos_d;
    dir_e                 dir_q, dir_d;
    logic [PWM_WIDTH-1:0] duty_q, duty_d;
    dir_e                 duty_dir_q, duty_dir_d;
    logic [NUM_LEDS-1:0]  ring_q, ring_d;
    logic [PWM_WIDTH-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [NUM_LEDS-1:0]  led_q, led_d;
    logic                 tick_q, tick_d;

    logic tick_int;
    logic mode_change;

    assign tick_int    = &prescaler_q;
    assign mode_change = (mode_req_q != mode_act_q);

    // Pattern of the active mode from current state; registered into LED every clock.
    always_comb begin
        led_d = '0;
        unique case (mode_act_q)
            ModeBinary:  led_d = step_q;
            ModeScan:    led_d = NUM_LEDS'(1) << pos_q;
            ModeBreathe: led_d = {NUM_LEDS{pwm_cnt_q < duty_q}};
            ModeRotate:  led_d = ring_q;
        endcase
    end

    always_comb begin
        prescaler_d = prescaler_q + DIV_WIDTH'(1);
        pwm_cnt_d   = pwm_cnt_q + PWM_WIDTH'(1);
        tick_d      = tick_int;
        mode_act_d  = mode_act_q;
        step_d      = step_q;
        pos_d       = pos_q;
        dir_d       = dir_q;
        duty_d      = duty_q;
        duty_dir_d  = duty_dir_q;
        ring_d      = ring_q;

        if (mode_change) begin
            // Entering a mode restarts it cleanly; a coincident tick is swallowed.
            mode_act_d  = mode_req_q;
            prescaler_d = '0;
            step_d      = '0;
            pos_d       = '0;
            dir_d       = DirUp;
            duty_d      = '0;
            duty_dir_d  = DirUp;
            ring_d      = NUM_LEDS'(1);
        end else if (tick_int) begin
            unique case (mode_act_q)
                ModeBinary: begin
                    step_d = step_q + NUM_LEDS'(1);
                end
                ModeScan: begin
                    if (NUM_LEDS > 1) begin
                        if (dir_q == DirUp) begin
                            if (pos_q == POS_MAX) begin
                                dir_d = DirDown;
                                pos_d = pos_q - POS_WIDTH'(1);
                            end else begin
                                pos_d = pos_q + POS_WIDTH'(1);
                            end
                        end else begin
                            if (pos_q == '0) begin
                                dir_d = DirUp;
                                pos_d = pos_q + POS_WIDTH'(1);
                            end else begin
                                pos_d = pos_q - POS_WIDTH'(1);
                            end
                        end
                    end
                end
                ModeBreathe: begin
                    // Triangle turnaround: endpoints are visited once, never held.
                    if (duty_dir_q == DirUp) begin
                        if (duty_q == DUTY_MAX) begin
                            duty_dir_d = DirDown;
                            duty_d     = duty_q - PWM_WIDTH'(1);
                        end else begin
                            duty_d = duty_q + PWM_WIDTH'(1);
                        end
                    end else begin
                        if (duty_q == '0) begin
                            duty_dir_d = DirUp;
                            duty_d     = duty_q + PWM_WIDTH'(1);
                        end else begin
                            duty_d = duty_q - PWM_WIDTH'(1);
                        end
                    end
                end
                ModeRotate: begin
                    ring_d = (ring_q << 1) | (ring_q >> (NUM_LEDS - 1));
                end
            endcase
        end
    end

    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            prescaler_q <= '0;
            mode_meta_q <= 2'b00;
            mode_req_q  <= ModeBinary;
            mode_act_q  <= ModeBinary;
            step_q      <= '0;
            pos_q       <= '0;
            dir_q       <= DirUp;
            duty_q      <= '0;
            duty_dir_q  <= DirUp;
            ring_q      <= NUM_LEDS'(1);
            pwm_cnt_q   <= '0;
            led_q       <= '0;
            tick_q      <= 1'b0;
        end else begin
            prescaler_q <= prescaler_d;
            mode_meta_q <= MODE;
            mode_req_q  <= mode_e'(mode_meta_q);
            mode_act_q  <= mode_act_d;
            step_q      <= step_d;
            pos_q       <= pos_d;
            dir_q       <= dir_d;
            duty_q      <= duty_d;
            duty_dir_q  <= duty_dir_d;
            ring_q      <= ring_d;
            pwm_cnt_q   <= pwm_cnt_d;
            led_q       <= led_d;
            tick_q      <= tick_d;
        end
    end

    assign LED      = led_q;
    assign TICK     = tick_q;
    assign MODE_ACT = mode_act_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen: closed-form pattern model checked every
// clock, plus directed literal sequences and randomized mode/reset stimulus.
module tb_led_pattern_gen;

    localparam int N  = 4;
    localparam int DW = 3;
    localparam int PW = 4;
    localparam int TICK_PERIOD = 1 << DW;
    localparam int PWM_PERIOD  = 1 << PW;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] mode  = 2'd0;
    logic [N-1:0] led;
    logic       tick;
    logic [1:0] mode_act;

    led_pattern_gen #(
        .NUM_LEDS (N),
        .DIV_WIDTH(DW),
        .PWM_WIDTH(PW)
    ) dut (
        .CLK_IN  (clk),
        .RST_N   (rst_n),
        .MODE    (mode),
        .LED     (led),
        .TICK    (tick),
        .MODE_ACT(mode_act)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model: time since mode entry, ticks taken in the mode, free-running PWM phase.
    int         m_pres;
    int         m_pwm;
    int         m_k;
    logic [1:0] m_s1, m_req, m_act;
    logic [N-1:0] m_led;
    logic       m_tick;

    function automatic logic [N-1:0] exp_pattern(logic [1:0] act, int k, int pwm);
        int r;
        int duty;
        if (act == 2'd0) return (N)'(k % (1 << N));
        if (act == 2'd1) begin
            if (N == 1) return (N)'(1);
            r = k % (2 * (N - 1));
            if (r >= N) r = 2 * (N - 1) - r;
            return (N)'(1 << r);
        end
        if (act == 2'd2) begin
            r = k % (2 * (PWM_PERIOD - 1));
            duty = (r <= PWM_PERIOD - 1) ? r : 2 * (PWM_PERIOD - 1) - r;
            return (pwm < duty) ? '1 : '0;
        end
        return (N)'(1 << (k % N));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pres <= 0;
            m_pwm  <= 0;
            m_k    <= 0;
            m_s1   <= 2'd0;
            m_req  <= 2'd0;
            m_act  <= 2'd0;
            m_led  <= '0;
            m_tick <= 1'b0;
        end else begin
            m_led  <= exp_pattern(m_act, m_k, m_pwm);
            m_tick <= (m_pres == TICK_PERIOD - 1);
            if (m_req != m_act) begin
                m_act  <= m_req;
                m_pres <= 0;
                m_k    <= 0;
            end else begin
                m_pres <= (m_pres + 1) % TICK_PERIOD;
                if (m_pres == TICK_PERIOD - 1) m_k <= m_k + 1;
            end
            m_pwm <= (m_pwm + 1) % PWM_PERIOD;
            m_req <= m_s1;
            m_s1  <= mode;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_led", 32'(led), 32'(m_led));
            check("model_tick", 32'(tick), 32'(m_tick));
            check("model_mode_act", 32'(mode_act), 32'(m_act));
        end
    end

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    task automatic wait_tick();
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tick === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout("wait_tick");
    endtask

    task automatic wait_act(input logic [1:0] target, output int n);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (mode_act === target) begin
                n = i;
                break;
            end
        end
        if (n == 0) timeout("wait_mode_act");
    endtask

    task automatic async_reset_pulse(input int offset);
        #(offset) rst_n = 1'b0;
        #1;
        check("rst_led", 32'(led), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_mode_act", 32'(mode_act), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int j;
        int lit;
        int hold;
        int offs;
        logic [N-1:0] scan_exp [7];
        logic [N-1:0] rot_exp [3];
        scan_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
        rot_exp  = '{4'b0100, 4'b1000, 4'b0001};

        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        rst_n  = 1'b1;

        // Run in rotate mode, then reset mid-cycle with MODE back at 0.
        mode = 2'd3;
        repeat (20) @(negedge clk);
        mode = 2'd0;
        async_reset_pulse(2);

        for (int i = 0; i < 16; i++) begin
            wait_tick();
            @(negedge clk);
            check("binary_led", 32'(led), 32'((i + 1) % 16));
        end

        wait_tick();
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (tick === 1'b1) begin
                n = i;
                break;
            end
        end
        check("tick_period", 32'(n), 32'd8);

        mode = 2'd1;
        wait_act(2'd1, n);
        check("scan_act_latency", 32'(n), 32'd3);
        @(negedge clk);
        check("scan_led_start", 32'(led), 32'b0001);
        for (int i = 0; i < 7; i++) begin
            wait_tick();
            @(negedge clk);
            check("scan_led", 32'(led), 32'(scan_exp[i]));
        end

        // Time the switch to rotate so the change edge coincides with tick_i.
        wait_tick();
        repeat (5) @(negedge clk);
        mode = 2'd3;
        wait_act(2'd3, n);
        check("rot_act_latency", 32'(n), 32'd3);
        check("switch_on_tick", 32'(tick), 32'd1);
        @(negedge clk);
        check("ring_reset", 32'(led), 32'b0001);
        j = 0;
        for (int i = 2; i <= 20; i++) begin
            @(negedge clk);
            if (led === 4'b0010) begin
                j = i;
                break;
            end
        end
        check("first_rotate_delay", 32'(j), 32'd9);
        for (int i = 0; i < 3; i++) begin
            wait_tick();
            @(negedge clk);
            check("rotate_led", 32'(led), 32'(rot_exp[i]));
        end

        mode = 2'd2;
        wait_act(2'd2, n);
        lit = 0;
        repeat (8) begin
            @(negedge clk);
            if (led !== 4'b0000) lit++;
        end
        check("breathe_duty0_lit", 32'(lit), 32'd0);
        repeat (32) wait_tick();

        // One-clock glitch to scan must settle back to breathe.
        mode = 2'd1;
        @(negedge clk);
        mode = 2'd2;
        repeat (12) @(negedge clk);
        check("glitch_settle", 32'(mode_act), 32'd2);

        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(0, 7) == 0) begin
                offs = $urandom_range(1, 3);
                if ($urandom_range(0, 1) == 1) offs += 5;
                async_reset_pulse(offs);
            end else begin
                mode = 2'($urandom_range(0, 3));
                hold = ($urandom_range(0, 3) == 0) ? 1 : $urandom_range(2, 60);
                repeat (hold) @(negedge clk);
            end
        end
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
